// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding,
// legal operand widths and counter sizing.
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam int unsigned WIDTH_MIN = 8;
  localparam int unsigned WIDTH_MAX = 32;

  // Legal widths are the powers of two between the limits: 8, 16, 32.
  function automatic bit width_legal(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX) && ((w & (w - 1)) == 0);
  endfunction

  // Iteration counter must reach WIDTH itself without wrapping.
  function automatic int unsigned cnt_bits(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mul_seq32_if.sv
// Request/result bundle of the sequential multiplier.
// master drives the request side, slave is the multiplier itself.
interface mul_seq32_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic                   start;
  logic                   flush;
  logic                   signed_op;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     prod;
  logic                   ovf;

  modport master (
    output start, flush, signed_op, a, b,
    input  busy, done, prod, ovf
  );

  modport slave (
    input  start, flush, signed_op, a, b,
    output busy, done, prod, ovf
  );

endinterface

// File: rtl/adder32.sv
// Common 32-bit ripple adder cell with carry in/out.
module adder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'b0, i_cin};

endmodule

// File: rtl/mul_step.sv
// One combinational add-and-shift iteration of the multiplier, plus the
// two's-complement negation used by the sign-fix cycle.
module mul_step
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [2*WIDTH-1:0] i_prod,
  output logic [2*WIDTH-1:0] o_step,
  output logic [2*WIDTH-1:0] o_neg
);

  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_carry;

  assign w_add_a = 32'(i_prod[2*WIDTH-1:WIDTH]);
  assign w_add_b = 32'(i_mcand);

  adder32 u_add (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // Narrow widths run zero-padded through the 32-bit cell, so their carry
  // lands at bit WIDTH of the sum; at full width it is the cell carry-out.
  assign w_carry = w_cout | (|(w_sum >> WIDTH));

  // Conditionally add the multiplicand into the upper half, then shift right.
  always_comb begin
    o_step = i_prod >> 1;
    if (i_prod[0]) begin
      o_step = {w_carry, w_sum[WIDTH-1:0], i_prod[WIDTH-1:1]};
    end
  end

  assign o_neg = -i_prod;

endmodule

// File: rtl/mul_seq32.sv
// Sequential shift-add multiplier (MUL/IMUL), one iteration per cycle.
// Optional feature macro: MUL_SIGNED_EN enables signed operation (IMUL)
// via magnitude multiply followed by a one-cycle negation (FIX state).
module mul_seq32
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  mul_seq32_if.slave bus
);

  localparam int unsigned CW = cnt_bits(WIDTH);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("mul_seq32: WIDTH must be 8, 16 or 32");
  end

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic               r_neg;
  logic               r_sgn;
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;

  logic               w_sgn;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_negp;

`ifdef MUL_SIGNED_EN
  assign w_sgn = bus.signed_op;
`else
  assign w_sgn = 1'b0;
`endif

  // Signed operands are multiplied as magnitudes; the sign is restored in FIX.
  assign w_a_mag = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  mul_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_mcand(r_mcand),
    .i_prod (r_prod),
    .o_step (w_step),
    .o_neg  (w_negp)
  );

  // Overflow: upper half is not the zero/sign extension of the lower half.
  function automatic logic f_ovf(input logic [2*WIDTH-1:0] p, input logic s);
    if (s) begin
      return p[2*WIDTH-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
    end
    return p[2*WIDTH-1:WIDTH] != '0;
  endfunction

  // FSM, iteration counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_neg   <= 1'b0;
      r_sgn   <= 1'b0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_mcand <= w_a_mag;
            r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
            r_cnt   <= '0;
            r_sgn   <= w_sgn;
            r_neg   <= w_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end
        end
        S_RUN: begin
          r_prod <= w_step;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            if (r_neg) begin
              r_state <= S_FIX;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_ovf   <= f_ovf(w_step, r_sgn);
            end
          end
        end
        S_FIX: begin
          r_prod  <= w_negp;
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_ovf   <= f_ovf(w_negp, r_sgn);
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.prod = r_prod;
  assign bus.ovf  = r_ovf;

endmodule
